sap1_controller_sequencer: RTL and testbench
============================================

// Module: sap1_controller_sequencer
// PURPOSE
//   Controller-sequencer for the SAP-1 datapath: a 6-state T-state ring counter plus
//   instruction decode that drives every control line on the W-bus datapath
//   (PC, MAR, RAM, IR, A, ALU, B, OUT). Opcode comes from the IR upper nibble.
//   Supports free-run and single-step operation, and halts on HLT.
// PARAMETERS
//   OP_LDA  4'h0  load A from RAM[addr]
//   OP_ADD  4'h1  A <= A + RAM[addr]
//   OP_SUB  4'h2  A <= A - RAM[addr]
//   OP_OUT  4'hE  OUT <= A
//   OP_HLT  4'hF  stop sequencing
// PORTS
//   CLK        in   1  system clock, all state on posedge
//   CLR        in   1  asynchronous, active-high reset
//   opcode     in   4  IR[7:4]
//   run        in   1  1 = free-run, 0 = single-step
//   step       in   1  level from step button, synchronous to CLK; rising edge = one T-state
//   t_state    out  6  one-hot ring counter, bit0 = T1 .. bit5 = T6
//   Cp         out  1  PC increment
//   Ep         out  1  PC drives W bus
//   Lm_bar     out  1  MAR load (active-low)
//   CE_bar     out  1  RAM drives W bus (active-low)
//   Li_bar     out  1  IR load (active-low)
//   Ei_bar     out  1  IR low nibble drives W bus (active-low)
//   La_bar     out  1  A load (active-low)
//   Ea         out  1  A drives W bus
//   Su         out  1  ALU subtract select
//   Eu         out  1  ALU drives W bus
//   Lb_bar     out  1  B load (active-low)
//   Lo_bar     out  1  OUT load (active-low)
//   HLT        out  1  halted flag, registered
// BEHAVIOUR
// - Reset (CLR=1, async): t_state=6'b000001, HLT=0, step-edge register=0. While CLR=1,
//   all control outputs are forced inactive (active-high=0, _bar=1).
// - Advance enable adv = ~HLT & (run | (step & ~step_q)); step_q <= step every cycle.
//   On adv, t_state rotates left; T6 -> T1. Without adv, t_state holds.
// - Control outputs: combinational decode of t_state and opcode. Exactly one
//   bus driver (Ep, CE_bar, Ei_bar, Ea, Eu) is active in any T-state, or none.
//   T1 (address): Ep=1, Lm_bar=0
//   T2 (increment): Cp=1
//   T3 (memory): CE_bar=0, Li_bar=0
//   T4: LDA/ADD/SUB: Ei_bar=0, Lm_bar=0 | OUT: Ea=1, Lo_bar=0 | HLT: none
//   T5: LDA: CE_bar=0, La_bar=0 | ADD/SUB: CE_bar=0, Lb_bar=0 | others: none
//   T6: ADD: Eu=1, La_bar=0 | SUB: Eu=1, Su=1, La_bar=0 | others: none
// - Undefined opcodes execute as NOP: fetch T1-T3, no controls in T4-T6.
// - HLT: HLT register sets on the posedge where t_state==T4 and opcode==OP_HLT, and the
//   counter does not advance on that edge. Afterwards t_state stays T4, all controls
//   stay inactive, and step/run are ignored. Only CLR clears it.
// - Control lines are gated with ~CLR and are only valid for a full cycle. Datapath
//   registers capture on the posedge that ends the T-state; this is the same edge that
//   advances t_state.
// - In step mode, a held step advances exactly once per 0->1 transition.
//   Toggling run mid-instruction is legal and does not reset t_state.
// - CLR during any T-state (mid-instruction) returns to T1 immediately. The partially
//   executed instruction is abandoned.
// TESTING
//   1. Assert CLR, release -> t_state=000001, Ep=1, Lm_bar=0, all other controls inactive,
//      HLT=0.
//   2. run=1, opcode=4'h0 (LDA) -> T1..T6 over 6 cycles; T4 Ei_bar=0,Lm_bar=0;
//      T5 CE_bar=0,La_bar=0; T6 no controls; 7th cycle back at T1.
//   3. run=1, opcode=4'h2 (SUB) -> T5 Lb_bar=0,CE_bar=0; T6 Eu=1,Su=1,La_bar=0.
//      With opcode=4'h1, T6 has Su=0.
//   4. run=1, opcode=4'hF -> HLT=1 after T4 edge; t_state stays 001000 for 20 cycles;
//      step pulses have no effect; CLR then gives T1, HLT=0.
//   5. run=0, step held high 5 cycles, then low, then high -> exactly 2 advances
//      (T1->T2->T3).
//   6. opcode=4'h1, assert CLR asynchronously during T5 (mid-cycle) -> t_state=000001
//      before the next edge; Lb_bar/CE_bar deassert immediately. Opcode 4'h7 gives no
//      T4-T6 controls.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 T-state ring counter, step/run sequencing, halt and control decode
module sap1_controller_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  input  logic       run,
  input  logic       step,
  output logic [5:0] t_state,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_bar,
  output logic       CE_bar,
  output logic       Li_bar,
  output logic       Ei_bar,
  output logic       La_bar,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_bar,
  output logic       Lo_bar,
  output logic       HLT
);
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [5:0] T1 = 6'b000001;
  logic step_q, halt_now, adv, en;
  logic lda, add, sub, out, mem_ref, arith;
  assign lda      = opcode == OP_LDA;
  assign add      = opcode == OP_ADD;
  assign sub      = opcode == OP_SUB;
  assign out      = opcode == OP_OUT;
  assign mem_ref  = lda | add | sub;
  assign arith    = add | sub;
  assign halt_now = ~HLT & t_state[3] & (opcode == OP_HLT);
  assign adv      = ~HLT & ~halt_now & (run | (step & ~step_q));
  assign en       = ~CLR & ~HLT;
  // Ring counter advances on run or a step rising edge; halting freezes it at T4
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      t_state <= T1;
      HLT     <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q  <= step;
      HLT     <= HLT | halt_now;
      t_state <= adv ? {t_state[4:0], t_state[5]} : t_state;
    end
  // Control lines decoded from T-state and opcode, all forced inactive in reset or halt
  always_comb begin
    Cp     = en & t_state[1];
    Ep     = en & t_state[0];
    Lm_bar = ~(en & (t_state[0] | (t_state[3] & mem_ref)));
    CE_bar = ~(en & (t_state[2] | (t_state[4] & mem_ref)));
    Li_bar = ~(en & t_state[2]);
    Ei_bar = ~(en & t_state[3] & mem_ref);
    La_bar = ~(en & ((t_state[4] & lda) | (t_state[5] & arith)));
    Ea     = en & t_state[3] & out;
    Su     = en & t_state[5] & sub;
    Eu     = en & t_state[5] & arith;
    Lb_bar = ~(en & t_state[4] & arith);
    Lo_bar = ~(en & t_state[3] & out);
  end
endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb_sap1_controller_sequencer: directed and randomized checks against an instruction-level model
module tb_sap1_controller_sequencer;
  logic CLK = 0, CLR = 0, run = 0, step = 0;
  logic [3:0] opcode = 0;
  logic [5:0] t_state;
  logic Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, HLT;
  int checks = 0, failures = 0;
  int m_ph = 0;
  logic m_hlt = 0, m_sq = 0;
  localparam logic [11:0] BAR_MASK = 12'h3E3;
  logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7, 4'h3};

  sap1_controller_sequencer dut (
    .CLK(CLK), .CLR(CLR), .opcode(opcode), .run(run), .step(step), .t_state(t_state),
    .Cp(Cp), .Ep(Ep), .Lm_bar(Lm_bar), .CE_bar(CE_bar), .Li_bar(Li_bar), .Ei_bar(Ei_bar),
    .La_bar(La_bar), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb_bar(Lb_bar), .Lo_bar(Lo_bar), .HLT(HLT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] ctl_vec();
    return {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar};
  endfunction

  // Bits: 11 Cp, 10 Ep, 9 Lm, 8 CE, 7 Li, 6 Ei, 5 La, 4 Ea, 3 Su, 2 Eu, 1 Lb, 0 Lo (active sense)
  function automatic logic [11:0] expect_ctl(int ph, logic [3:0] op, logic halted, logic clr);
    logic [11:0] a = '0;
    if (!halted && !clr)
      case (ph)
        0: begin a[10] = 1; a[9] = 1; end
        1: a[11] = 1;
        2: begin a[8] = 1; a[7] = 1; end
        3: if (op <= 4'h2) begin a[6] = 1; a[9] = 1; end
           else if (op == 4'hE) begin a[4] = 1; a[0] = 1; end
        4: if (op == 4'h0) begin a[8] = 1; a[5] = 1; end
           else if (op == 4'h1 || op == 4'h2) begin a[8] = 1; a[1] = 1; end
        5: if (op == 4'h1 || op == 4'h2) begin a[2] = 1; a[5] = 1; a[3] = (op == 4'h2); end
        default: ;
      endcase
    return a ^ BAR_MASK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".t_state"}, 32'(t_state), 32'(6'b1 << m_ph));
    chk({tag, ".ctl"}, 32'(ctl_vec()), 32'(expect_ctl(m_ph, opcode, m_hlt, CLR)));
    chk({tag, ".hlt"}, 32'(HLT), 32'(m_hlt));
  endtask

  task automatic cyc(input string tag, input logic r, input logic s, input logic [3:0] op);
    logic halt_now, adv;
    run = r; step = s; opcode = op;
    #1 check_all(tag);
    @(posedge CLK);
    halt_now = !m_hlt && m_ph == 3 && op == 4'hF;
    adv = !m_hlt && !halt_now && (r || (s && !m_sq));
    m_sq = s;
    if (halt_now) m_hlt = 1;
    if (adv) m_ph = (m_ph + 1) % 6;
    #1;
  endtask

  task automatic do_clr(input string tag);
    CLR = 1;
    #1;
    chk({tag, ".clr_t"}, 32'(t_state), 32'h1);
    chk({tag, ".clr_ctl"}, 32'(ctl_vec()), 32'(BAR_MASK));
    chk({tag, ".clr_hlt"}, 32'(HLT), 32'h0);
    @(posedge CLK);
    #1 CLR = 0;
    m_ph = 0; m_hlt = 0; m_sq = 0;
  endtask

  initial begin
    do_clr("reset");
    opcode = 4'h0;
    #1 check_all("t1_after_reset");
    for (int i = 0; i < 7; i++) cyc("lda", 1, 0, 4'h0);
    chk("lda_wrap_t1", 32'(t_state), 32'h2);
    do_clr("pre_sub");
    for (int i = 0; i < 6; i++) cyc("sub", 1, 0, 4'h2);
    for (int i = 0; i < 6; i++) cyc("add", 1, 0, 4'h1);
    for (int i = 0; i < 6; i++) cyc("out", 1, 0, 4'hE);
    for (int i = 0; i < 5; i++) cyc("hlt_run", 1, 0, 4'hF);
    chk("hlt_set", 32'(HLT), 32'h1);
    for (int i = 0; i < 20; i++) cyc("hlt_hold", 1, i[0], 4'hF);
    for (int i = 0; i < 4; i++) cyc("hlt_other_op", 0, i[0], 4'h1);
    chk("hlt_t4", 32'(t_state), 32'h8);
    do_clr("hlt_clr");
    for (int i = 0; i < 5; i++) cyc("step_hold", 0, 1, 4'h0);
    cyc("step_low", 0, 0, 4'h0);
    cyc("step_high", 0, 1, 4'h0);
    cyc("step_high2", 0, 1, 4'h0);
    chk("step_two_adv", 32'(t_state), 32'h4);
    cyc("run_toggle", 1, 0, 4'h0);
    cyc("run_toggle", 0, 0, 4'h0);
    cyc("run_toggle", 1, 0, 4'h0);
    do_clr("pre_midclr");
    for (int i = 0; i < 4; i++) cyc("add_to_t5", 1, 0, 4'h1);
    chk("at_t5_lb", 32'(Lb_bar), 32'h0);
    #2 CLR = 1;
    #1;
    chk("midclr_t", 32'(t_state), 32'h1);
    chk("midclr_lb", 32'(Lb_bar), 32'h1);
    chk("midclr_ce", 32'(CE_bar), 32'h1);
    @(posedge CLK);
    #1 CLR = 0;
    m_ph = 0; m_hlt = 0; m_sq = 0;
    for (int i = 0; i < 7; i++) cyc("nop7", 1, 0, 4'h7);
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 29);
      if ($urandom_range(0, 39) == 0) do_clr("rnd_clr");
      else cyc("rnd", 1'($urandom_range(0, 2) == 0), 1'($urandom), r == 0 ? 4'hF : (r == 1 ? 4'($urandom) : ops[r % 6]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
